// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one block memory between icache and dcache
module mem_arbiter #(
  parameter int c_block_size = 2,
  parameter int c_line_size  = 32,
  parameter int address_size = 32,
  localparam int BA = address_size - c_block_size - 2,
  localparam int BW = (2 ** c_block_size) * c_line_size
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_read,
  input  logic [BA-1:0] i_address,
  output logic [BW-1:0] i_readdata,
  output logic          i_busywait,
  output logic          i_read_done,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [BA-1:0] d_address,
  input  logic [BW-1:0] d_writedata,
  output logic [BW-1:0] d_readdata,
  output logic          d_busywait,
  output logic          d_read_done,
  output logic          d_write_done,
  output logic          m_read,
  output logic          m_write,
  output logic [BA-1:0] m_address,
  output logic [BW-1:0] m_writedata,
  input  logic [BW-1:0] m_readdata,
  input  logic          m_busywait,
  input  logic          m_read_done,
  input  logic          m_write_done
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR} state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t        state, state_nx;
  logic          last_grant, last_grant_nx;
  logic          m_read_nx, m_write_nx;
  logic [BA-1:0] m_address_nx;
  logic [BW-1:0] m_writedata_nx;
  logic          d_req;

  // Completion is signalled only by the done pulses; busywait is informational.
  wire unused_m_busywait = m_busywait;

  assign d_req      = d_read | d_write;
  assign i_readdata = m_readdata;
  assign d_readdata = m_readdata;
  assign i_busywait = i_read & ~i_read_done;
  assign d_busywait = d_req & ~(d_read_done | d_write_done);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GRANT_I;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
    end else begin
      state       <= state_nx;
      last_grant  <= last_grant_nx;
      m_read      <= m_read_nx;
      m_write     <= m_write_nx;
      m_address   <= m_address_nx;
      m_writedata <= m_writedata_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    last_grant_nx  = last_grant;
    m_read_nx      = m_read;
    m_write_nx     = m_write;
    m_address_nx   = m_address;
    m_writedata_nx = m_writedata;
    i_read_done    = 1'b0;
    d_read_done    = 1'b0;
    d_write_done   = 1'b0;

    case (state)
      IDLE: begin
        m_read_nx  = 1'b0;
        m_write_nx = 1'b0;
        // On a tie the side that was not served last wins; write beats read on the dcache side.
        if (i_read && (!d_req || last_grant == GRANT_D)) begin
          state_nx       = SERVE_I;
          m_read_nx      = 1'b1;
          m_address_nx   = i_address;
          m_writedata_nx = '0;
        end else if (d_req) begin
          m_address_nx   = d_address;
          m_writedata_nx = d_writedata;
          if (d_write) begin
            state_nx   = SERVE_D_WR;
            m_write_nx = 1'b1;
          end else begin
            state_nx  = SERVE_D_RD;
            m_read_nx = 1'b1;
          end
        end
      end
      SERVE_I: begin
        i_read_done = m_read_done & ~reset;
        if (m_read_done) begin
          state_nx      = IDLE;
          m_read_nx     = 1'b0;
          last_grant_nx = GRANT_I;
        end
      end
      SERVE_D_RD: begin
        d_read_done = m_read_done & ~reset;
        if (m_read_done) begin
          state_nx      = IDLE;
          m_read_nx     = 1'b0;
          last_grant_nx = GRANT_D;
        end
      end
      SERVE_D_WR: begin
        d_write_done = m_write_done & ~reset;
        if (m_write_done) begin
          state_nx      = IDLE;
          m_write_nx    = 1'b0;
          last_grant_nx = GRANT_D;
        end
      end
      default: begin
        state_nx   = IDLE;
        m_read_nx  = 1'b0;
        m_write_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;
  localparam int BA = 28;
  localparam int BW = 128;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_read, d_read, d_write;
  logic [BA-1:0] i_address, d_address;
  logic [BW-1:0] d_writedata, m_readdata;
  logic          m_busywait, m_read_done, m_write_done;
  logic [BW-1:0] i_readdata, d_readdata, m_writedata;
  logic          i_busywait, i_read_done, d_busywait, d_read_done, d_write_done;
  logic          m_read, m_write;
  logic [BA-1:0] m_address;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
    .i_busywait(i_busywait), .i_read_done(i_read_done),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait), .d_read_done(d_read_done),
    .d_write_done(d_write_done),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_busywait(m_busywait), .m_read_done(m_read_done),
    .m_write_done(m_write_done)
  );

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: who owns memory (0 none, 1 icache read, 2 dcache read, 3 dcache write).
  int            who = 0;
  bit            last_was_d = 1'b0;
  bit            mvalid = 1'b0;
  logic [BA-1:0] exp_addr;
  logic [BW-1:0] exp_wdata;

  always @(posedge clock) begin
    if (reset) begin
      who = 0; last_was_d = 1'b0; mvalid = 1'b1;
      exp_addr = '0; exp_wdata = '0;
    end else if (who != 0) begin
      if ((who == 3 && m_write_done) || (who != 3 && m_read_done)) begin
        last_was_d = (who != 1);
        who = 0;
      end
    end else if (i_read && (!(d_read || d_write) || last_was_d)) begin
      who = 1; exp_addr = i_address;
    end else if (d_read || d_write) begin
      who = d_write ? 3 : 2; exp_addr = d_address; exp_wdata = d_writedata;
    end
  end

  always @(negedge clock) begin
    logic ei, edr, edw;
    if (mvalid) begin
      ei  = !reset && who == 1 && m_read_done;
      edr = !reset && who == 2 && m_read_done;
      edw = !reset && who == 3 && m_write_done;
      chk("m_read", m_read, (who == 1 || who == 2));
      chk("m_write", m_write, who == 3);
      chk("i_read_done", i_read_done, ei);
      chk("d_read_done", d_read_done, edr);
      chk("d_write_done", d_write_done, edw);
      chk("i_busywait", i_busywait, i_read && !ei);
      chk("d_busywait", d_busywait, (d_read || d_write) && !(edr || edw));
      chk("i_readdata", i_readdata, m_readdata);
      chk("d_readdata", d_readdata, m_readdata);
      if (who != 0) chk("m_address", m_address, exp_addr);
      if (who == 3) chk("m_writedata", m_writedata, exp_wdata);
    end
  end

  task automatic step;
    @(posedge clock);
    #2;
  endtask

  localparam logic [BW-1:0] WB  = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [BW-1:0] RD1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [BW-1:0] RD2 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  initial begin
    reset = 1'b1; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_writedata = '0; m_readdata = '0;
    m_busywait = 0; m_read_done = 0; m_write_done = 0;
    repeat (2) step;
    reset = 1'b0;
    #1;
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_address", m_address, 0);
    chk("rst_m_writedata", m_writedata, 0);
    step;

    // icache alone, memory completes 5 cycles after the strobe rises
    i_read = 1; i_address = 28'h0000010;
    step; #1;
    chk("a_m_read", m_read, 1);
    chk("a_m_address", m_address, 28'h0000010);
    d_address = 28'h0ABCDEF; d_writedata = RD2;
    repeat (4) step;
    m_readdata = RD1; m_read_done = 1; #1;
    chk("a_i_read_done", i_read_done, 1);
    chk("a_i_readdata", i_readdata, RD1);
    chk("a_d_read_done", d_read_done, 0);
    chk("a_m_address_hold", m_address, 28'h0000010);
    step; m_read_done = 0; i_read = 0; #1;
    chk("a_m_read_off", m_read, 0);
    step;

    // first tie after reset goes to dcache; second tie (dcache re-requests) goes to icache
    i_read = 1; i_address = 28'h20; d_read = 1; d_address = 28'h30;
    step; #1;
    chk("b_tie1_addr", m_address, 28'h30);
    repeat (2) step;
    m_readdata = RD2; m_read_done = 1; #1;
    chk("b_d_read_done", d_read_done, 1);
    chk("b_i_read_done", i_read_done, 0);
    step; m_read_done = 0; d_address = 28'h31; #1;
    chk("b_turnaround", m_read, 0);
    step; #1;
    chk("b_tie2_addr", m_address, 28'h20);
    repeat (2) step;
    m_read_done = 1; #1;
    chk("b_i_read_done2", i_read_done, 1);
    step; m_read_done = 0; i_read = 0;
    step; #1;
    chk("b_d_regrant", m_address, 28'h31);
    step; m_read_done = 1; #1;
    chk("b_d_read_done2", d_read_done, 1);
    step; m_read_done = 0; d_read = 0;
    step;

    // write-back then refill of the same block
    d_write = 1; d_address = 28'h40; d_writedata = WB;
    step; #1;
    chk("c_m_write", m_write, 1);
    chk("c_m_read", m_read, 0);
    chk("c_m_writedata", m_writedata, WB);
    repeat (3) step;
    m_write_done = 1; #1;
    chk("c_d_write_done", d_write_done, 1);
    chk("c_d_read_done", d_read_done, 0);
    step; m_write_done = 0; d_write = 0; d_read = 1;
    step; #1;
    chk("c_refill_read", m_read, 1);
    chk("c_refill_addr", m_address, 28'h40);
    step; m_readdata = RD1; m_read_done = 1; #1;
    chk("c_d_read_done2", d_read_done, 1);
    step; m_read_done = 0; d_read = 0;
    step;

    // read and write together is a write; a read-done pulse meanwhile is ignored
    d_read = 1; d_write = 1; d_address = 28'h50; d_writedata = RD2;
    step; #1;
    chk("d_write_only", m_write, 1);
    chk("d_no_read", m_read, 0);
    m_read_done = 1; #1;
    chk("d_stray_rd_done", d_read_done, 0);
    step; m_read_done = 0; #1;
    chk("d_still_writing", m_write, 1);
    m_write_done = 1; #1;
    chk("d_write_done", d_write_done, 1);
    chk("d_read_done", d_read_done, 0);
    step; m_write_done = 0; d_read = 0; d_write = 0;
    step;

    // reset two cycles into a write-back abandons it
    d_write = 1; d_address = 28'h60; d_writedata = WB;
    step; #1;
    chk("e_m_write", m_write, 1);
    step; step;
    reset = 1; m_write_done = 1; #1;
    chk("e_no_done_in_reset", d_write_done, 0);
    step; reset = 0; d_write = 0; #1;
    chk("e_m_write_low", m_write, 0);
    chk("e_late_done", d_write_done, 0);
    step; m_write_done = 0; #1;
    chk("e_idle", m_write, 0);

    // stray read-done while idle
    m_read_done = 1; #1;
    chk("f_i_done", i_read_done, 0);
    chk("f_d_done", d_read_done, 0);
    step; m_read_done = 0; #1;
    chk("f_m_read", m_read, 0);
    step;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter c_block_size, default 2, log2 of words per cache block.
REQ-002 SHALL have parameter c_line_size, default 32, bits per word.
REQ-003 SHALL have parameter address_size, default 32, byte-address width; block address width BA = address_size - c_block_size - 2; block width BW = 2**c_block_size * c_line_size.
REQ-004 SHALL have ports, one per line:
  clock  input  1  single clock; all state updates on rising edge
  reset  input  1  synchronous, active-high
  i_read  input  1  icache block-read request
  i_address  input  BA  icache block address
  i_readdata  output  BW  block data to icache
  i_busywait  output  1  icache request pending
  i_read_done  output  1  icache read complete pulse
  d_read  input  1  dcache block-read request
  d_write  input  1  dcache block-write (write-back) request
  d_address  input  BA  dcache block address
  d_writedata  input  BW  dcache write block
  d_readdata  output  BW  block data to dcache
  d_busywait  output  1  dcache request pending
  d_read_done  output  1  dcache read complete pulse
  d_write_done  output  1  dcache write complete pulse
  m_read  output  1  memory read strobe (registered)
  m_write  output  1  memory write strobe (registered)
  m_address  output  BA  memory block address (registered)
  m_writedata  output  BW  memory write block (registered)
  m_readdata  input  BW  memory read block
  m_busywait  input  1  memory busy (informational; not used for completion)
  m_read_done  input  1  one-cycle read complete pulse
  m_write_done  input  1  one-cycle write complete pulse

Function
REQ-005 SHALL implement FSM states IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR.
REQ-006 In IDLE with exactly one requester active, SHALL move to its serve state on the next edge.
REQ-007 In IDLE with both active, SHALL grant the requester not granted last (round-robin via 1-bit last_grant register).
REQ-008 If d_read and d_write are both high, SHALL treat it as a write (SERVE_D_WR).
REQ-009 On entering a serve state, SHALL register m_address/m_writedata from the winner and assert exactly one of m_read/m_write, holding all four stable until completion.
REQ-010 Latency: request high at edge k in IDLE -> m_read/m_write high in cycle k+1.
REQ-011 SHALL never assert m_read and m_write simultaneously; both low in IDLE.
REQ-012 In SERVE_I, m_read_done SHALL pass combinationally to i_read_done in the same cycle; next edge -> IDLE, m_read low, last_grant = I.
REQ-013 In SERVE_D_RD/SERVE_D_WR, m_read_done/m_write_done SHALL pass combinationally to d_read_done/d_write_done; next edge -> IDLE, last_grant = D.
REQ-014 A done pulse of the wrong type for the current state, or in IDLE, SHALL be ignored.
REQ-015 i_readdata and d_readdata SHALL both equal m_readdata combinationally; only the matching done pulse qualifies it.
REQ-016 x_busywait SHALL be high whenever that requester's request is high, except in the cycle its done pulse is asserted.
REQ-017 After IDLE return, SHALL spend at least one cycle in IDLE before a new grant (one-cycle turnaround); a requester still high re-arbitrates then.
REQ-018 Requester dropping its request mid-service SHALL NOT abort the memory transaction; FSM waits for done.
REQ-019 Address/data changes from a requester while not granted SHALL not affect m_* outputs.

Reset
REQ-020 On reset high at an edge: state = IDLE, last_grant = I (first tie goes to dcache), m_read = m_write = 0, m_address = 0, m_writedata = 0.
REQ-021 Reset mid-transaction SHALL abandon it; m_* strobes low from the following cycle; no done pulses forwarded while reset high.

Verification
REQ-022 Icache only: i_read=1, i_address=0x0000010; memory done after 5 cycles -> m_read=1, m_address=0x0000010 from k+1; i_read_done one cycle, i_readdata=m_readdata; d_* done stay 0.
REQ-023 Tie after reset: i_read and d_read same edge -> dcache served first, then icache after IDLE cycle; second tie -> icache first.
REQ-024 Write-back then refill: d_write=1 with d_writedata=0xDEADBEEF_..._0001, then d_read -> m_write with exact data, d_write_done pulse, IDLE, then m_read, d_read_done.
REQ-025 d_read and d_write both high -> m_write only, d_write_done pulses, d_read_done stays 0.
REQ-026 Reset asserted 2 cycles into SERVE_D_WR -> m_write 0 next cycle, state IDLE, late m_write_done ignored.
REQ-027 Stray m_read_done in IDLE -> no done outputs, state stays IDLE.
